// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry defaults, monitor state encoding and RGB packing.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CW_DEF = 12;
    typedef enum logic {SYNC_WAIT = 1'b0, FRAME = 1'b1} state_t;
    function automatic logic [23:0] rgb24(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, g, b};
    endfunction
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers HS/VS/Vde and flags the VS activation and Vde falling edges.
module vga_edge_det #(
    parameter bit VS_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic HS,
    input  logic VS,
    input  logic Vde,
    output logic hs_q,
    output logic vs_active,
    output logic vs_rise,
    output logic de_fall
);
    logic vs_q, de_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else begin
            hs_q <= HS;
            vs_q <= VS;
            de_q <= Vde;
        end
    // Pulses fire on the edge that loads the new level, keeping every output one cycle behind its input.
    assign vs_active = VS == VS_POL;
    assign vs_rise = vs_active && (vs_q != VS_POL);
    assign de_fall = de_q && !Vde;
endmodule

// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor: recovers pixel coordinates from a VGA stream and checks geometry,
// frame checksum and one probe pixel.
module vga_stream_monitor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter bit VS_POL = 1'b0,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          HS,
    input  logic          VS,
    input  logic          Vde,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    input  logic          err_clear,
    input  logic [CW-1:0] probe_x,
    input  logic [CW-1:0] probe_y,
    output logic [CW-1:0] x_rx,
    output logic [CW-1:0] y_rx,
    output logic          pix_valid,
    output logic [23:0]   pix_rgb,
    output logic          frame_done,
    output logic [31:0]   frame_sum,
    output logic [23:0]   probe_rgb,
    output logic          line_err,
    output logic          frame_err
);
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA = CW'(V_ACTIVE);
    state_t state, state_nx;
    logic hs_q, hs_unused, vs_active, vs_rise, de_fall;
    logic in_frame, pix_en, frame_end, line_set, frame_set;
    logic [CW-1:0] x_cnt, y_cnt, xb, yb;
    logic [31:0] acc, accb;
    logic [23:0] rgb;

    vga_edge_det #(.VS_POL(VS_POL)) u_edge (
        .clk(clk), .rst(rst), .HS(HS), .VS(VS), .Vde(Vde),
        .hs_q(hs_q), .vs_active(vs_active), .vs_rise(vs_rise), .de_fall(de_fall)
    );

    assign hs_unused = hs_q;
    assign rgb = rgb24(R, G, B);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= SYNC_WAIT;
        else state <= state_nx;

    always_comb state_nx = vs_rise ? FRAME : state;

    always_comb begin
        in_frame = state == FRAME;
        pix_en = in_frame && Vde;
        frame_end = in_frame && vs_rise;
        line_set = in_frame && de_fall && !vs_rise && (x_cnt != HA);
        frame_set = (frame_end && (y_cnt != VA)) || (pix_en && vs_active);
    end

    // A frame boundary restarts the counters before any pixel on that same cycle is counted.
    assign xb = vs_rise ? '0 : x_cnt;
    assign yb = vs_rise ? '0 : y_cnt;
    assign accb = vs_rise ? 32'd0 : acc;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
            acc <= '0;
            x_rx <= '0;
            y_rx <= '0;
            pix_valid <= 1'b0;
            pix_rgb <= '0;
            frame_done <= 1'b0;
            frame_sum <= '0;
            probe_rgb <= '0;
            line_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            x_cnt <= de_fall ? '0 : (pix_en && xb != CMAX) ? xb + 1'b1 : xb;
            y_cnt <= (in_frame && de_fall && !vs_rise && yb != CMAX) ? yb + 1'b1 : yb;
            acc <= pix_en ? accb + 32'(rgb) : accb;
            pix_valid <= pix_en;
            pix_rgb <= rgb;
            if (pix_en) begin
                x_rx <= xb;
                y_rx <= yb;
            end
            if (pix_en && xb == probe_x && yb == probe_y) probe_rgb <= rgb;
            if (frame_end) frame_sum <= acc;
            frame_done <= frame_end;
            line_err <= line_set || (line_err && !err_clear);
            frame_err <= frame_set || (frame_err && !err_clear);
        end
endmodule

// File: doc/vga_stream_monitor.md
Name: vga_stream_monitor

Overview:
- Receive-side counterpart of the VGA timing generator and pixel renderer. Consumes the outgoing video stream (HS, VS, Vde, R/G/B) on the pixel clock.
- Recovers pixel coordinates from the sync and data-enable signals alone. Checks line and frame geometry, computes a per-frame pixel checksum and captures one probe pixel.
- Used as an in-fabric checker for the snake renderer and as a bench scoreboard. Sits in parallel with the display output and never drives the video path.

Parameters:
- H_ACTIVE, 640, expected Vde-high pixels per line
- V_ACTIVE, 480, expected active lines per frame
- VS_POL, 0, VS active level (0 = active-low)
- CW, 12, coordinate width (x_rx, y_rx, probe_x, probe_y)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- HS  in  1  horizontal sync; monitored only, no checks applied
- VS  in  1  vertical sync, polarity per VS_POL
- Vde  in  1  video data enable
- R, G, B  in  8 each  pixel colour
- err_clear  in  1  clears sticky error flags
- probe_x, probe_y  in  CW each  coordinate to capture
- x_rx, y_rx  out  CW each  recovered coordinate of the current pixel
- pix_valid  out  1  x_rx/y_rx/pix_rgb valid
- pix_rgb  out  24  registered {R,G,B}
- frame_done  out  1  one-cycle pulse at the end of each complete frame
- frame_sum  out  32  checksum of the last complete frame
- probe_rgb  out  24  pixel captured at (probe_x, probe_y)
- line_err  out  1  sticky: a line had an active length != H_ACTIVE
- frame_err  out  1  sticky: the line count at VS != V_ACTIVE, or Vde high while VS asserted

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; counters, accumulator and registered inputs 0; state SYNC_WAIT.
- Input stage: all inputs are registered once. Every output lags its stimulus by exactly 1 cycle.
- vs_rise: the registered VS transitions from inactive to active.
- SYNC_WAIT: ignore all video. On vs_rise, go to FRAME and clear the line counter, x counter and accumulator. No errors and no frame_done for this first, partial frame.
- FRAME: on each Vde-high cycle:
  - pix_valid = 1, x_rx = x counter, y_rx = line counter.
  - Accumulator += zero-extended {R,G,B}, mod 2^32.
  - x counter increments.
- FRAME, when (x_rx, y_rx) equals (probe_x, probe_y), pix_rgb is written to probe_rgb; it holds otherwise.
- FRAME, on each Vde falling edge:
  - If x counter != H_ACTIVE, set line_err.
  - Line counter increments; x counter clears.
- FRAME, on vs_rise:
  - If line counter != V_ACTIVE, set frame_err.
  - frame_sum <= accumulator; frame_done pulses for one cycle. This fires even when frame_err is set.
  - Accumulator, line counter and x counter clear; state stays FRAME.
- Vde high while VS is active: set frame_err; the pixel is still counted.
- Counter overflow: the x and line counters saturate at 2^CW-1 and do not wrap. An oversized line is therefore still flagged.
- err_clear: clears both sticky flags. If it coincides with a new error event in the same cycle, the flag is set (set wins).
- Reset mid-frame: returns to SYNC_WAIT. The next frame is discarded as partial, and frame_sum/probe_rgb read 0 until the first complete frame.
- pix_valid = 0 in SYNC_WAIT and during blanking. x_rx/y_rx hold their last value while pix_valid = 0.

Decomposition:
- Shared package vga_pkg: H_ACTIVE/V_ACTIVE defaults, the CW default, the rgb24 packing function ({R,G,B}), and the state encoding (SYNC_WAIT, FRAME).
- One natural sub-module: vga_edge_det, which registers HS/VS/Vde and emits the rise/fall pulses with VS polarity applied. Everything else stays in the top level.

Test Plan:
- Reset then one partial frame, then a complete frame (H_ACTIVE=8, V_ACTIVE=4, constant RGB 0x010203) -> frame_done pulses only after the complete frame; frame_sum = 32*0x010203 = 0x00204060; no errors.
- Gradient pixels (R=x, G=y, B=0), probe (5,2) -> probe_rgb = 0x050200; x_rx/y_rx match the driven coordinates one cycle later on every pix_valid.
- One line driven with 7 active pixels -> line_err = 1 persists across frames; err_clear -> 0; err_clear in the same cycle as the next short line -> line_err stays 1.
- Frame with 5 active lines -> frame_err = 1 at vs_rise; frame_done still pulses; frame_sum covers all 40 pixels.
- Vde asserted while VS is active -> frame_err = 1.
- rst pulsed low mid-line (asynchronously, between clock edges) -> outputs 0 immediately; the next frame produces no frame_done; the following frame's sum is correct.
